// File: rtl/mine_placer_pkg.sv
// Shared minesweeper constants, cell codes, placer state type and the
// first-click exclusion helper.
package minesweeper_pkg;

  localparam int EZ_BD_W   = 9;
  localparam int EZ_BD_H   = 9;
  localparam int EZ_MN_NUM = 10;

  localparam logic [3:0] CELL_MINE = 4'd9;
  localparam logic [3:0] CELL_FLAG = 4'd10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR,
    ST_GEN,
    ST_WT,
    ST_CHK,
    ST_WR_MINE,
    ST_NB_RD,
    ST_NB_WT,
    ST_NB_WR,
    ST_DONE
  } placer_state_t;

  function automatic logic in_excl_zone(input logic [3:0] gx, input logic [3:0] gy,
                                        input logic [3:0] ux, input logic [3:0] uy);
    logic [3:0] dx;
    logic [3:0] dy;
    dx = (gx >= ux) ? gx - ux : ux - gx;
    dy = (gy >= uy) ? gy - uy : uy - gy;
    return (dx <= 4'd1) && (dy <= 4'd1);
  endfunction

endpackage

// File: rtl/mine_placer.sv
// Clears the board RAM, places MN_NUM mines away from the first click and
// bumps the neighbour count of every non-mine cell around each new mine.
module mine_placer
  import minesweeper_pkg::*;
#(
  parameter int BD_W   = EZ_BD_W,
  parameter int BD_H   = EZ_BD_H,
  parameter int MN_NUM = EZ_MN_NUM
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  userx,
  input  logic [3:0]  usery,
  input  logic [15:0] rand_num,
  input  logic [3:0]  bd_rdata,
  output logic [6:0]  bd_addr,
  output logic [3:0]  bd_wdata,
  output logic        bd_wren,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0]        W_LAST      = 4'(BD_W - 1);
  localparam logic [3:0]        H_LAST      = 4'(BD_H - 1);
  localparam logic signed [4:0] W_S         = 5'(BD_W);
  localparam logic signed [4:0] H_S         = 5'(BD_H);
  localparam logic [7:0]        MINES_TOTAL = 8'(MN_NUM);

  placer_state_t state, state_nx, nb_after;
  logic [3:0] ux, uy, cx, cy, gx, gy, k, k_step;
  logic [7:0] mines;
  logic [3:0] sx, sy;
  logic       sample_ok, nb_ok;
  logic signed [4:0] nx, ny;
  logic [6:0] nb_addr;
  logic       unused_rand;

  assign unused_rand = ^rand_num[15:8];

  function automatic logic [6:0] cell_addr(input logic [3:0] col, input logic [3:0] row);
    return 7'(int'(row) * BD_W + int'(col));
  endfunction

  // Neighbour advance is folded into the skip/write cycle and k=4 (the mine
  // itself) is stepped over, so a neighbour costs 3 cycles in bounds, 1 outside.
  always_comb begin
    sx        = rand_num[3:0];
    sy        = rand_num[7:4];
    sample_ok = (sx <= W_LAST) && (sy <= H_LAST) && !in_excl_zone(sx, sy, ux, uy);
    nx        = $signed({1'b0, gx}) + $signed(5'(k % 4'd3)) - 5'sd1;
    ny        = $signed({1'b0, gy}) + $signed(5'(k / 4'd3)) - 5'sd1;
    nb_ok     = (nx >= 5'sd0) && (nx < W_S) && (ny >= 5'sd0) && (ny < H_S);
    nb_addr   = cell_addr(nx[3:0], ny[3:0]);
    k_step    = (k == 4'd3) ? 4'd5 : k + 4'd1;
    if (k != 4'd8)               nb_after = ST_NB_RD;
    else if (mines == MINES_TOTAL) nb_after = ST_DONE;
    else                         nb_after = ST_GEN;
  end

  always_comb begin
    state_nx = state;
    bd_addr  = '0;
    bd_wdata = '0;
    bd_wren  = 1'b0;
    case (state)
      ST_IDLE:
        if (start && (userx <= W_LAST) && (usery <= H_LAST)) state_nx = ST_CLR;
      ST_CLR: begin
        bd_addr = cell_addr(cx, cy);
        bd_wren = 1'b1;
        if ((cx == W_LAST) && (cy == H_LAST)) state_nx = ST_GEN;
      end
      ST_GEN:
        if (sample_ok) begin
          bd_addr  = cell_addr(sx, sy);
          state_nx = ST_WT;
        end
      ST_WT: begin
        bd_addr  = cell_addr(gx, gy);
        state_nx = ST_CHK;
      end
      ST_CHK: begin
        bd_addr  = cell_addr(gx, gy);
        state_nx = (bd_rdata == CELL_MINE) ? ST_GEN : ST_WR_MINE;
      end
      ST_WR_MINE: begin
        bd_addr  = cell_addr(gx, gy);
        bd_wdata = CELL_MINE;
        bd_wren  = 1'b1;
        state_nx = ST_NB_RD;
      end
      ST_NB_RD:
        if (nb_ok) begin
          bd_addr  = nb_addr;
          state_nx = ST_NB_WT;
        end else begin
          state_nx = nb_after;
        end
      ST_NB_WT: begin
        bd_addr  = nb_addr;
        state_nx = ST_NB_WR;
      end
      ST_NB_WR: begin
        bd_addr = nb_addr;
        if (bd_rdata != CELL_MINE) begin
          bd_wren  = 1'b1;
          bd_wdata = bd_rdata + 4'd1;
        end
        state_nx = nb_after;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      ux    <= '0;
      uy    <= '0;
      cx    <= '0;
      cy    <= '0;
      gx    <= '0;
      gy    <= '0;
      k     <= '0;
      mines <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE:
          if (state_nx == ST_CLR) begin
            ux <= userx;
            uy <= usery;
            cx <= '0;
            cy <= '0;
          end
        ST_CLR:
          if (cx == W_LAST) begin
            cx <= '0;
            cy <= cy + 4'd1;
            if (cy == H_LAST) mines <= '0;
          end else begin
            cx <= cx + 4'd1;
          end
        ST_GEN:
          if (sample_ok) begin
            gx <= sx;
            gy <= sy;
          end
        ST_WR_MINE: begin
          mines <= mines + 8'd1;
          k     <= '0;
        end
        ST_NB_RD: if (!nb_ok) k <= k_step;
        ST_NB_WR: k <= k_step;
        default: ;
      endcase
    end
  end

  always_comb begin
    done = (state == ST_DONE);
    busy = (state != ST_IDLE) && (state != ST_DONE);
  end

endmodule
